// File: rtl/cmp_rr_sched.sv
// Round-robin scheduler that shares one unsigned magnitude comparator among NREQ requesters.
// Each grant runs IDLE -> CMP -> RSP; the tagged {gt,eq,lt} result is held until it is consumed.
module cmp_rr_sched #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_gt,
    output logic              rsp_eq,
    output logic              rsp_lt,
    output logic              busy,
    output logic [15:0]       op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_id;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic           r_gt;
    logic           r_eq;
    logic           r_lt;
    logic [15:0]    r_op_count;

    logic           w_found;
    logic [IDW-1:0] w_winner;
    logic [IDW:0]   w_idx;
    logic           w_gt;
    logic           w_eq;
    logic           w_lt;

    // Round-robin winner search: first valid requester starting at r_rr_ptr, wrapping mod NREQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ)) begin
                w_idx = w_idx - (IDW+1)'(NREQ);
            end else begin
                w_idx = w_idx;
            end
            if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[IDW-1:0];
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Accept strobe; gated by rst_n so nothing is acknowledged while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == S_IDLE) && w_found) begin
            req_ready[w_winner] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // The single shared compare stage.
    always_comb begin
        w_gt = (r_a > r_b);
        w_eq = (r_a == r_b);
        w_lt = (r_a < r_b);
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_next = S_CMP;
                else         w_next = S_IDLE;
            end
            S_CMP:  w_next = S_RSP;
            S_RSP: begin
                if (r_rsp_valid && rsp_ready) w_next = S_IDLE;
                else                          w_next = S_RSP;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Operand capture, result registration, response handshake and pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_gt        <= 1'b0;
            r_eq        <= 1'b0;
            r_lt        <= 1'b0;
            r_op_count  <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_a  <= req_a[int'(w_winner)*W +: W];
                        r_b  <= req_b[int'(w_winner)*W +: W];
                        r_id <= w_winner;
                    end
                end
                S_CMP: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_id;
                    r_gt        <= w_gt;
                    r_eq        <= w_eq;
                    r_lt        <= w_lt;
                end
                S_RSP: begin
                    if (r_rsp_valid && rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_op_count  <= r_op_count + 16'd1;
                        r_rr_ptr    <= (r_id == IDW'(NREQ-1)) ? '0 : r_id + IDW'(1);
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_gt    = r_gt;
    assign rsp_eq    = r_eq;
    assign rsp_lt    = r_lt;
    assign busy      = (r_state != S_IDLE);
    assign op_count  = r_op_count;

endmodule
